// File: rtl/matrix_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mem_responder_pkg
// Description : Shared widths, coprocessor word addresses and FSM encoding
//               for the matrix memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_mem_responder_pkg;

    localparam int WORD_W         = 256;
    localparam int ELEM_W         = 8;
    localparam int BYTES_PER_WORD = 32;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    localparam logic [7:0] ADDR_A   = 8'd0;
    localparam logic [7:0] ADDR_B   = 8'd1;
    localparam logic [7:0] ADDR_RES = 8'd2;

    // Host select value with no backing word.
    localparam logic [1:0] SEL_INVALID = 2'd3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DUMP   = 2'd3
    } state_e;

endpackage : matrix_mem_responder_pkg
`default_nettype wire

// File: rtl/matrix_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_byte_packer
// Description : 256-bit staging register with a 5-bit byte counter. Bytes are
//               written (load path) or read (dump path) MSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_byte_packer
    import matrix_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  word_t             i_load_word,
    input  logic              i_push,
    input  logic [ELEM_W-1:0] i_push_byte,
    input  logic              i_advance,
    output word_t             o_word,
    output logic [ELEM_W-1:0] o_byte,
    output logic [CNT_W-1:0]  o_count
);

    word_t             r_stage;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        w_lsb;

    // Byte k lives at bits 255-8k:248-8k, whose LSB index is 8*(31-k).
    assign w_lsb   = {~r_count, 3'b000};
    assign o_word  = r_stage;
    assign o_byte  = r_stage[w_lsb +: ELEM_W];
    assign o_count = r_count;

    // Staging/counter update: clear > snapshot > byte write > byte advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_stage <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_stage <= i_load_word;
            r_count <= '0;
        end else if (i_push) begin
            r_stage[w_lsb +: ELEM_W] <= i_push_byte;
            r_count                  <= r_count + 1'b1;
        end else if (i_advance) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : matrix_byte_packer
`default_nettype wire

// File: rtl/matrix_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mem_responder
// Description : Three-word matrix memory with a 1-cycle coprocessor port and
//               a host byte-stream port for loading and dumping words.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_mem_responder
    import matrix_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_address,
    input  logic              i_wren,
    input  word_t             i_wr_data,
    output word_t             o_data,
    output logic              o_addr_err,
    input  logic [1:0]        i_host_sel,
    input  logic              i_host_in_valid,
    output logic              o_host_in_ready,
    input  logic [ELEM_W-1:0] i_host_in_byte,
    input  logic              i_host_in_last,
    input  logic              i_host_dump_req,
    output logic              o_host_out_valid,
    input  logic              i_host_out_ready,
    output logic [ELEM_W-1:0] o_host_out_byte,
    output logic              o_host_out_last,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

    state_e            r_state;
    logic [1:0]        r_sel;
    logic              r_in_ready;
    logic              r_out_valid;
    word_t             r_mem [3];
    word_t             r_data;
    logic              r_addr_err;

    word_t             w_rd_word;
    word_t             w_sel_word;
    word_t             w_stage;
    logic [CNT_W-1:0]  w_count;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_start_load;
    logic              w_start_dump;
    logic              w_conflict;
    logic              w_commit_we;

    assign w_in_hs      = (r_state == ST_LOAD) && i_host_in_valid && r_in_ready;
    assign w_out_hs     = (r_state == ST_DUMP) && r_out_valid && i_host_out_ready;
    assign w_start_load = (r_state == ST_IDLE) && i_host_in_valid;
    assign w_start_dump = (r_state == ST_IDLE) && !i_host_in_valid && i_host_dump_req;
    // A coprocessor write to the word being committed takes the cycle.
    assign w_conflict   = i_wren && (r_sel != SEL_INVALID) && (i_address == {6'b0, r_sel});
    assign w_commit_we  = (r_state == ST_COMMIT) && (r_sel != SEL_INVALID) && !w_conflict;

    assign o_data           = r_data;
    assign o_addr_err       = r_addr_err;
    assign o_host_in_ready  = r_in_ready;
    assign o_host_out_valid = r_out_valid;
    assign o_host_out_last  = r_out_valid && (w_count == c_LAST_IDX);
    assign o_busy           = (r_state != ST_IDLE);

    // Coprocessor read mux; out-of-range addresses read as zero.
    always_comb begin
        w_rd_word = '0;
        case (i_address)
            ADDR_A:   w_rd_word = r_mem[0];
            ADDR_B:   w_rd_word = r_mem[1];
            ADDR_RES: w_rd_word = r_mem[2];
            default:  w_rd_word = '0;
        endcase
    end

    // Host-selected word for the dump snapshot; the invalid select yields zero.
    always_comb begin
        w_sel_word = '0;
        case (i_host_sel)
            2'd0:    w_sel_word = r_mem[0];
            2'd1:    w_sel_word = r_mem[1];
            2'd2:    w_sel_word = r_mem[2];
            default: w_sel_word = '0;
        endcase
    end

    matrix_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_start_load),
        .i_load      (w_start_dump),
        .i_load_word (w_sel_word),
        .i_push      (w_in_hs),
        .i_push_byte (i_host_in_byte),
        .i_advance   (w_out_hs),
        .o_word      (w_stage),
        .o_byte      (o_host_out_byte),
        .o_count     (w_count)
    );

    // Registered coprocessor read data and out-of-range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_data     <= w_rd_word;
            r_addr_err <= (i_address > ADDR_RES);
        end
    end

    // Memory words: coprocessor writes always land; host commits fill idle slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (i_wren && (i_address == 8'(i))) begin
                    r_mem[i] <= i_wr_data;
                end else if (w_commit_we && (r_sel == 2'(i))) begin
                    r_mem[i] <= w_stage;
                end
            end
        end
    end

    // Host transfer FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= 2'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_host_in_valid) begin
                        r_state    <= ST_LOAD;
                        r_sel      <= i_host_sel;
                        r_in_ready <= 1'b1;
                    end else if (i_host_dump_req) begin
                        r_state     <= ST_DUMP;
                        r_sel       <= i_host_sel;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_in_hs && (i_host_in_last || (w_count == c_LAST_IDX))) begin
                        r_state    <= ST_COMMIT;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    if (!w_conflict) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DUMP: begin
                    if (w_out_hs && (w_count == c_LAST_IDX)) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : matrix_mem_responder
`default_nettype wire

// File: doc/matrix_mem_responder.md
MATRIX_MEM_RESPONDER -- requirements
Module: matrix_mem_responder

Interface
REQ-001 clock  in  1  system clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous active-low reset.
REQ-003 address  in  8  coprocessor word address (0 = A, 1 = B, 2 = result).
REQ-004 wren  in  1  coprocessor write enable, sampled at rising edge.
REQ-005 wr_data  in  256  coprocessor write word (result matrix, 8-bit elements, element 0 at bits 255:248).
REQ-006 data  out  256  registered read word for the address sampled on the previous edge.
REQ-007 addr_err  out  1  one-cycle pulse when a coprocessor access targets an address above 2.
REQ-008 host_sel  in  2  target word (0..2) for a host load or dump, sampled when a transfer starts.
REQ-009 host_in_valid / host_in_ready  in / out  1 / 1  host byte-load handshake.
REQ-010 host_in_byte, host_in_last  in  8, 1  load byte; last marks the final byte of a matrix.
REQ-011 host_dump_req  in  1  one-cycle request to stream word host_sel out.
REQ-012 host_out_valid / host_out_ready  out / in  1 / 1  dump byte handshake.
REQ-013 host_out_byte, host_out_last  out  8, 1  dump byte; last asserted with byte 31.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Storage SHALL be three 256-bit words; a read of address > 2 SHALL return zero, and a write to address > 2 SHALL be ignored; both SHALL pulse addr_err.
REQ-016 Coprocessor reads SHALL have 1-cycle latency: data after edge N reflects mem[address at edge N], including a write committed at edge N-1.
REQ-017 A coprocessor write SHALL update mem[address] at the edge where wren = 1, whatever the FSM state.
REQ-018 FSM states SHALL be IDLE, LOAD, COMMIT, DUMP; IDLE->LOAD on host_in_valid; IDLE->DUMP on host_dump_req; when both occur in the same cycle, LOAD wins and the dump request is dropped.
REQ-019 LOAD SHALL assert host_in_ready; each handshake SHALL place the byte at bits 255-8k:248-8k of a staging register, where k is a 5-bit byte counter, and then increment k.
REQ-020 LOAD SHALL enter COMMIT after the byte with host_in_last = 1, or after byte 31 regardless of last; the bytes not loaded SHALL be zero (staging is cleared on entry to LOAD).
REQ-021 COMMIT SHALL write staging into mem[host_sel latched] and return to IDLE; if wren = 1 with a matching address in that cycle, the coprocessor write SHALL win and COMMIT SHALL hold one more cycle, then write.
REQ-022 DUMP SHALL snapshot the selected word on entry and stream bytes 0..31, MSB byte first; a byte SHALL advance only on host_out_valid and host_out_ready both high; host_out_last SHALL accompany byte 31; DUMP returns to IDLE after that handshake.
REQ-023 host_sel = 3 SHALL be treated as invalid: the load is consumed and discarded, and a dump emits 32 zero bytes.
REQ-024 host_in_ready SHALL be 0 outside LOAD; host_out_valid SHALL be 0 outside DUMP.

Reset
REQ-025 While reset_n = 0: FSM in IDLE, counter 0, all mem words, staging and snapshot cleared, data = 0, and addr_err, host_in_ready, host_out_valid, host_out_last, busy = 0.
REQ-026 Reset mid-LOAD or mid-DUMP SHALL abort the transfer immediately with no partial commit.

Structure
REQ-027 A shared package SHALL hold WORD_W = 256, ELEM_W = 8, BYTES_PER_WORD = 32, ADDR_A/B/RES = 0/1/2, and the FSM state enum.
REQ-028 One sub-module, matrix_byte_packer (staging register plus byte counter), SHALL be used; it is shared by the LOAD and DUMP paths.

Verification
REQ-029 Load 1, 2, 3, 4 with last on the 4th byte, host_sel = 0, then read address 0 -> data = {1, 2, 3, 4, 224'b0} one cycle later.
REQ-030 wren = 1 at address 2 with {6, 8, 10, 12, 0...}, then dump sel 2 -> 32 bytes 6, 8, 10, 12, 0×28, with last on byte 32.
REQ-031 Dump with host_out_ready toggling every other cycle -> byte order intact, no duplicate or lost bytes, 64 cycles total.
REQ-032 COMMIT to sel 1 in the same cycle as a coprocessor write to address 1 -> the commit lands one cycle later, and the final mem[1] equals the host data.
REQ-033 Read of address 7 -> data = 0 and addr_err pulses for one cycle; a write to address 7 leaves all three words unchanged.
REQ-034 reset_n low after 10 loaded bytes -> mem[sel] stays 0, busy = 0, and the next load starts at byte 0.
